// File: rtl/row_fill_engine.sv
// row_fill_engine: memory-side miss responder for the row-buffer cache controller.
// Optional dirty-victim writeback, then the row fill, then a one-cycle MemOK pulse.
module row_fill_engine #(
    parameter int ROWW   = 17,
    parameter int T_WB   = 8,
    parameter int T_FILL = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic [ROWW-1:0] RowId,
    input  logic            victim_dirty,
    input  logic [ROWW-1:0] victim_row,
    output logic            MemOK,
    output logic            busy,
    output logic            mem_valid,
    output logic [1:0]      mem_cmd,
    output logic [ROWW-1:0] mem_row,
    input  logic            mem_ready,
    output logic [15:0]     fill_count,
    output logic [15:0]     wb_count
);
    typedef enum logic [2:0] {
        IDLE, WB_ISSUE, WB_WAIT, FILL_ISSUE, FILL_WAIT, DONE
    } state_t;

    localparam logic [7:0] WB_LOAD   = 8'(T_WB - 1);
    localparam logic [7:0] FILL_LOAD = 8'(T_FILL - 1);
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_WB    = 2'b01;
    localparam logic [1:0] CMD_FILL  = 2'b10;

    state_t          state_q, state_d;
    logic            hold_q;
    logic [7:0]      cnt_q, cnt_d;
    logic [ROWW-1:0] row_q, row_d;
    logic [ROWW-1:0] vrow_q, vrow_d;
    logic [15:0]     fill_count_q, fill_count_d;
    logic [15:0]     wb_count_q, wb_count_d;
    logic            memok_q, memok_d;
    logic            busy_q, busy_d;
    logic            mem_valid_q, mem_valid_d;
    logic [1:0]      mem_cmd_q, mem_cmd_d;
    logic [ROWW-1:0] mem_row_q, mem_row_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        vrow_d       = vrow_q;
        fill_count_d = fill_count_q;
        wb_count_d   = wb_count_q;
        case (state_q)
            IDLE: begin
                // Only a fresh rising edge of hold starts a transaction.
                if (hold && !hold_q) begin
                    row_d   = RowId;
                    vrow_d  = victim_row;
                    state_d = victim_dirty ? WB_ISSUE : FILL_ISSUE;
                end
            end
            WB_ISSUE: begin
                if (mem_ready) begin
                    cnt_d   = WB_LOAD;
                    state_d = WB_WAIT;
                end else if (!hold) begin
                    state_d = IDLE;
                end
            end
            WB_WAIT: begin
                if (cnt_q == 8'd0) begin
                    wb_count_d = sat_inc(wb_count_q);
                    state_d    = FILL_ISSUE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            FILL_ISSUE: begin
                if (mem_ready) begin
                    cnt_d   = FILL_LOAD;
                    state_d = FILL_WAIT;
                end else if (!hold) begin
                    state_d = IDLE;
                end
            end
            FILL_WAIT: begin
                // A completed fill always counts; MemOK only if the miss is still pending.
                if (cnt_q == 8'd0) begin
                    fill_count_d = sat_inc(fill_count_q);
                    state_d      = hold ? DONE : IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered copies of the decode of the next state.
    always_comb begin
        memok_d     = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        mem_valid_d = 1'b0;
        mem_cmd_d   = CMD_NONE;
        mem_row_d   = '0;
        if (state_d == WB_ISSUE) begin
            mem_valid_d = 1'b1;
            mem_cmd_d   = CMD_WB;
            mem_row_d   = vrow_d;
        end else if (state_d == FILL_ISSUE) begin
            mem_valid_d = 1'b1;
            mem_cmd_d   = CMD_FILL;
            mem_row_d   = row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_q       <= 1'b0;
            cnt_q        <= '0;
            row_q        <= '0;
            vrow_q       <= '0;
            fill_count_q <= '0;
            wb_count_q   <= '0;
            memok_q      <= 1'b0;
            busy_q       <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_cmd_q    <= CMD_NONE;
            mem_row_q    <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            vrow_q       <= vrow_d;
            fill_count_q <= fill_count_d;
            wb_count_q   <= wb_count_d;
            memok_q      <= memok_d;
            busy_q       <= busy_d;
            mem_valid_q  <= mem_valid_d;
            mem_cmd_q    <= mem_cmd_d;
            mem_row_q    <= mem_row_d;
        end
    end

    assign MemOK      = memok_q;
    assign busy       = busy_q;
    assign mem_valid  = mem_valid_q;
    assign mem_cmd    = mem_cmd_q;
    assign mem_row    = mem_row_q;
    assign fill_count = fill_count_q;
    assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_row_fill_engine.sv
// Bench for row_fill_engine: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based transaction model.
module tb_row_fill_engine;
    localparam int ROWW   = 17;
    localparam int T_WB   = 8;
    localparam int T_FILL = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            hold = 1'b0;
    logic [ROWW-1:0] RowId = '0;
    logic            victim_dirty = 1'b0;
    logic [ROWW-1:0] victim_row = '0;
    logic            mem_ready = 1'b0;
    logic            MemOK, busy, mem_valid;
    logic [1:0]      mem_cmd;
    logic [ROWW-1:0] mem_row;
    logic [15:0]     fill_count, wb_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    row_fill_engine #(.ROWW(ROWW), .T_WB(T_WB), .T_FILL(T_FILL)) dut (
        .clk(clk), .rst(rst), .hold(hold), .RowId(RowId),
        .victim_dirty(victim_dirty), .victim_row(victim_row),
        .MemOK(MemOK), .busy(busy), .mem_valid(mem_valid), .mem_cmd(mem_cmd),
        .mem_row(mem_row), .mem_ready(mem_ready),
        .fill_count(fill_count), .wb_count(wb_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: a queue of pending memory commands plus a service timer.
    typedef struct {
        logic [1:0]      cmd;
        logic [ROWW-1:0] row;
    } mcmd_t;

    mcmd_t m_pend[$];
    int    m_serve = 0;
    bit    m_done  = 1'b0;
    bit    m_hprev = 1'b0;
    int    m_fill  = 0;
    int    m_wb    = 0;

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pend.delete();
                m_serve = 0;
                m_done  = 1'b0;
                m_hprev = 1'b0;
                m_fill  = 0;
                m_wb    = 0;
            end else begin
                if (m_done) begin
                    m_done = 1'b0;
                end else if (m_pend.size() == 0) begin
                    if (hold && !m_hprev) begin
                        if (victim_dirty) m_pend.push_back(mcmd_t'{2'b01, victim_row});
                        m_pend.push_back(mcmd_t'{2'b10, RowId});
                    end
                end else if (m_serve == 0) begin
                    if (mem_ready) m_serve = (m_pend[0].cmd == 2'b01) ? T_WB : T_FILL;
                    else if (!hold) m_pend.delete();
                end else begin
                    m_serve--;
                    if (m_serve == 0) begin
                        if (m_pend[0].cmd == 2'b01) begin
                            m_wb = sat16(m_wb);
                        end else begin
                            m_fill = sat16(m_fill);
                            m_done = hold;
                        end
                        void'(m_pend.pop_front());
                    end
                end
                m_hprev = hold;
            end
        end
    end

    task automatic cmp_model();
        bit              iss;
        logic [1:0]      ecmd;
        logic [ROWW-1:0] erow;
        iss  = (m_pend.size() > 0) && (m_serve == 0);
        ecmd = 2'b00;
        erow = '0;
        if (iss) begin
            ecmd = m_pend[0].cmd;
            erow = m_pend[0].row;
        end
        chk("rnd_busy",  32'(busy),      32'((m_pend.size() > 0) || m_done));
        chk("rnd_valid", 32'(mem_valid), 32'(iss));
        chk("rnd_cmd",   32'(mem_cmd),   32'(ecmd));
        chk("rnd_row",   32'(mem_row),   32'(erow));
        chk("rnd_memok", 32'(MemOK),     32'(m_done));
        chk("rnd_fill",  32'(fill_count), m_fill);
        chk("rnd_wb",    32'(wb_count),   m_wb);
    endtask

    typedef struct {
        logic [ROWW-1:0] row;
        logic            dirty;
        logic [ROWW-1:0] vrow;
        int              stall;
        int              exp_wb_cyc;
        int              exp_fill_cyc;
        int              exp_ok;
        int              exp_fill;
        int              exp_wb;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v);
        int stalls, ok_cyc, ok_n, wb_cyc, fl_cyc, row_bad;
        stalls = v.stall; ok_cyc = -1; ok_n = 0; wb_cyc = -1; fl_cyc = -1; row_bad = 0;
        hold = 1'b1; RowId = v.row; victim_dirty = v.dirty; victim_row = v.vrow; mem_ready = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 1) begin
                RowId      = ~v.row;
                victim_row = ~v.vrow;
            end
            if (mem_valid) begin
                if (mem_cmd == 2'b01) begin
                    if (wb_cyc < 0) wb_cyc = n;
                    if (mem_row !== v.vrow) row_bad++;
                end else if (mem_cmd == 2'b10) begin
                    if (fl_cyc < 0) fl_cyc = n;
                    if (mem_row !== v.row) row_bad++;
                end else begin
                    row_bad++;
                end
            end
            if (mem_valid && mem_cmd == 2'b10 && stalls > 0) begin
                mem_ready = 1'b0;
                stalls--;
            end else begin
                mem_ready = 1'b1;
            end
            if (MemOK) begin
                ok_n++;
                if (ok_cyc < 0) ok_cyc = n;
                hold = 1'b0;
            end
        end
        chk("vec_ok_cycle",   ok_cyc, v.exp_ok);
        chk("vec_ok_pulses",  ok_n, 1);
        chk("vec_wb_cycle",   wb_cyc, v.exp_wb_cyc);
        chk("vec_fill_cycle", fl_cyc, v.exp_fill_cyc);
        chk("vec_row_stable", row_bad, 0);
        chk("vec_fill_count", 32'(fill_count), v.exp_fill);
        chk("vec_wb_count",   32'(wb_count), v.exp_wb);
        chk("vec_idle",       32'(busy), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_memok"}, 32'(MemOK), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_valid"}, 32'(mem_valid), 0);
        chk({tag, "_cmd"},   32'(mem_cmd), 0);
        chk({tag, "_row"},   32'(mem_row), 0);
        chk({tag, "_fill"},  32'(fill_count), 0);
        chk({tag, "_wb"},    32'(wb_count), 0);
    endtask

    initial begin
        int ok_n, ok_cyc, f0, busy14;

        vecs[0] = '{17'h000A5, 1'b0, 17'h00000, 0, -1, 1, 14, 1, 0};
        vecs[1] = '{17'h00003, 1'b1, 17'h1F000, 0, 1, 10, 23, 2, 1};
        vecs[2] = '{17'h1ABCD, 1'b0, 17'h00000, 3, -1, 1, 17, 3, 1};
        vecs[3] = '{17'h0FFFF, 1'b1, 17'h00001, 2, 1, 10, 25, 4, 2};

        rst = 1'b1;
        step(); step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            step();
        end

        // Abort while the fill command is stalled.
        f0 = int'(fill_count);
        hold = 1'b1; victim_dirty = 1'b0; RowId = 17'h00055; mem_ready = 1'b0;
        step();
        chk("abort_issue_valid", 32'(mem_valid), 1);
        hold = 1'b0;
        step();
        chk("abort_issue_idle", 32'(busy), 0);
        ok_n = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (MemOK || mem_valid) ok_n++;
        end
        chk("abort_issue_quiet", ok_n, 0);
        chk("abort_issue_fill", 32'(fill_count), f0);

        // hold drops during the fill service time.
        hold = 1'b1; mem_ready = 1'b1;
        step(); step(); step();
        hold = 1'b0;
        ok_n = 0; busy14 = -1;
        for (int n = 4; n <= 20; n++) begin
            step();
            if (MemOK) ok_n++;
            if (n == 14) busy14 = int'(busy);
        end
        chk("abort_wait_memok", ok_n, 0);
        chk("abort_wait_busy14", busy14, 0);
        chk("abort_wait_fill", 32'(fill_count), f0 + 1);

        // hold held high for 40 cycles, with and without a glitch while busy.
        for (int pass = 0; pass < 2; pass++) begin
            hold = 1'b1; ok_n = 0; ok_cyc = -1;
            for (int n = 1; n <= 40; n++) begin
                step();
                if (pass == 1 && n == 4) hold = 1'b0;
                if (pass == 1 && n == 5) hold = 1'b1;
                if (MemOK) begin
                    ok_n++;
                    if (ok_cyc < 0) ok_cyc = n;
                end
            end
            chk("hold_high_pulses", ok_n, 1);
            chk("hold_high_cycle", ok_cyc, 14);
            hold = 1'b0;
            step();
        end

        // Reset in the middle of the writeback wait, then hold already high at release.
        hold = 1'b1; victim_dirty = 1'b1; victim_row = 17'h00003; RowId = 17'h00007; mem_ready = 1'b1;
        step(); step(); step(); step();
        chk("mid_wb_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        chk_all_zero("mid_rst");
        rst = 1'b0;
        step();
        chk("post_rst_accept_cmd", 32'(mem_cmd), 1);
        chk("post_rst_accept_row", 32'(mem_row), 3);
        ok_n = 0;
        for (int n = 0; n < 30; n++) begin
            step();
            if (MemOK) begin
                ok_n++;
                hold = 1'b0;
            end
        end
        chk("post_rst_memok", ok_n, 1);
        chk("post_rst_wb", 32'(wb_count), 1);

        // Saturation of the fill statistic.
        dut.fill_count_q = 16'hFFFE;
        step();
        chk("sat_preload", 32'(fill_count), 32'h0000FFFE);
        victim_dirty = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hold = 1'b1;
            for (int n = 0; n < 16; n++) step();
            hold = 1'b0;
            step();
            chk("sat_fill", 32'(fill_count), 32'h0000FFFF);
        end
        chk("sat_wb", 32'(wb_count), 1);

        // Randomized traffic against the reference model.
        rst = 1'b1; hold = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) hold = ~hold;
            mem_ready    = ($urandom_range(0, 2) != 0);
            RowId        = ROWW'($urandom);
            victim_row   = ROWW'($urandom);
            victim_dirty = $urandom_range(0, 1) == 1;
            rst          = ($urandom_range(0, 299) == 0);
            step();
            cmp_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
